// File: rtl/mul_seq_nb.sv
// Sequential shift-add multiplier: WIDTH-cycle latency, signed or unsigned per operation.
// Signed operands are reduced to magnitudes and the sign is reapplied when the result is written.
module mul_seq_nb #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is taken on a rising edge while not busy (IDLE or DONE);
    // busy is high for exactly WIDTH cycles after acceptance, then done pulses
    // for one cycle with the new out. start seen during busy is dropped.
    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic             neg_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             step;
    logic             last_bit;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_sum;
    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic             neg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept   = start && ((state_q == IDLE) || (state_q == DONE));
        step     = (state_q == RUN);
        last_bit = step && (cnt_q == CW'(WIDTH - 1));
        addend   = '0;
        if (mplier_q[cnt_q]) begin
            addend = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        end
        acc_sum  = acc_q + addend;
        // The most negative value maps onto itself, which is its correct unsigned magnitude.
        x_mag    = (signed_mode && x[WIDTH-1]) ? (~x + 1'b1) : x;
        y_mag    = (signed_mode && y[WIDTH-1]) ? (~y + 1'b1) : y;
        neg_d    = signed_mode && (x[WIDTH-1] ^ y[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out      <= '0;
        end else if (accept) begin
            mcand_q  <= x_mag;
            mplier_q <= y_mag;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + 1'b1;
            if (last_bit) begin
                out <= neg_q ? (~acc_sum + 1'b1) : acc_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_mul_seq_nb.sv
// Bench for mul_seq_nb: vector table, exhaustive 3-bit sweep, handshake corner
// sequences, and randomized 16-bit operations against an arithmetic model.
module tb_mul_seq_nb;

    logic        clk = 1'b0;
    logic        rst;

    logic        start3, mode3, busy3, done3;
    logic [2:0]  x3, y3;
    logic [5:0]  out3;
    logic        start8, mode8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] out8;
    logic        start16, mode16, busy16, done16;
    logic [15:0] x16, y16;
    logic [31:0] out16;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int          sel;
        logic        md;
        logic [15:0] xv;
        logic [15:0] yv;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[10];

    mul_seq_nb #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .signed_mode(mode3),
        .x(x3), .y(y3), .busy(busy3), .done(done3), .out(out3)
    );
    mul_seq_nb #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(mode8),
        .x(x8), .y(y8), .busy(busy8), .done(done8), .out(out8)
    );
    mul_seq_nb #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(mode16),
        .x(x16), .y(y16), .busy(busy16), .done(done16), .out(out16)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int width_of(int sel);
        return (sel == 0) ? 3 : ((sel == 1) ? 8 : 16);
    endfunction

    function automatic logic get_busy(int sel);
        return (sel == 0) ? busy3 : ((sel == 1) ? busy8 : busy16);
    endfunction

    function automatic logic get_done(int sel);
        return (sel == 0) ? done3 : ((sel == 1) ? done8 : done16);
    endfunction

    function automatic logic [31:0] get_out(int sel);
        return (sel == 0) ? {26'd0, out3} : ((sel == 1) ? {16'd0, out8} : out16);
    endfunction

    // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
    function automatic logic [31:0] model(int w, logic md, logic [15:0] xv, logic [15:0] yv);
        longint a;
        longint b;
        longint p;
        a = longint'(xv);
        b = longint'(yv);
        if (md && xv[w-1]) a = a - (64'sd1 <<< w);
        if (md && yv[w-1]) b = b - (64'sd1 <<< w);
        p = a * b;
        return 32'(p & ((64'sd1 <<< (2 * w)) - 1));
    endfunction

    // driver tasks
    task automatic set_in(int sel, logic st, logic md, logic [15:0] xv, logic [15:0] yv);
        case (sel)
            0: begin start3 = st; mode3 = md; x3 = xv[2:0]; y3 = yv[2:0]; end
            1: begin start8 = st; mode8 = md; x8 = xv[7:0]; y8 = yv[7:0]; end
            default: begin start16 = st; mode16 = md; x16 = xv; y16 = yv; end
        endcase
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One operation with inputs scrambled after acceptance; checks latency, busy length, result.
    task automatic do_op(int sel, logic md, logic [15:0] xv, logic [15:0] yv,
                         logic [31:0] exp, string name);
        int w;
        int busy_n;
        int lat;
        logic got;
        logic [31:0] act;
        w = width_of(sel);
        busy_n = 0;
        lat = 0;
        got = 1'b0;
        act = '0;
        @(negedge clk);
        set_in(sel, 1'b1, md, xv, yv);
        for (int c = 1; c <= w + 8; c++) begin
            @(negedge clk);
            if (get_busy(sel)) busy_n++;
            if (get_done(sel)) begin
                got = 1'b1;
                lat = c - 1;
                act = get_out(sel);
                break;
            end
            if (c == 1) set_in(sel, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end
        if (!got) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(w));
            check({name, "_busy"}, 32'(busy_n), 32'(w));
            check({name, "_out"}, act, exp);
        end
    endtask

    initial begin
        tbl[0] = '{1, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000, "s8_m128xm128"};
        tbl[1] = '{1, 1'b1, 16'h0080, 16'h007F, 32'h0000_C080, "s8_m128x127"};
        tbl[2] = '{1, 1'b1, 16'h00FF, 16'h0001, 32'h0000_FFFF, "s8_m1x1"};
        tbl[3] = '{1, 1'b1, 16'h0000, 16'h00FB, 32'h0000_0000, "s8_0xm5"};
        tbl[4] = '{0, 1'b0, 16'h0007, 16'h0007, 32'd49,        "u3_7x7"};
        tbl[5] = '{1, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, "u8_255x255"};
        tbl[6] = '{1, 1'b0, 16'h00C8, 16'h0003, 32'd600,       "u8_200x3"};
        tbl[7] = '{2, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, "s16_minxmin"};
        tbl[8] = '{2, 1'b1, 16'hFFFF, 16'h7FFF, 32'hFFFF_8001, "s16_m1xmax"};
        tbl[9] = '{1, 1'b1, 16'h007F, 16'h007F, 32'h0000_3F01, "s8_127x127"};

        rst = 1'b1;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_out%0d", s), get_out(s), 32'd0);
            check($sformatf("reset_busy%0d", s), 32'(get_busy(s)), 32'd0);
            check($sformatf("reset_done%0d", s), 32'(get_done(s)), 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].sel, tbl[i].md, tbl[i].xv, tbl[i].yv, tbl[i].exp, tbl[i].name);
        end

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                do_op(0, 1'b0, 16'(a), 16'(b), 32'(a * b), $sformatf("u3_%0dx%0d", a, b));
            end
        end

        // back-to-back: start held through done, second operands accepted in the done cycle
        begin
            int c1;
            int ndone;
            c1 = 0;
            ndone = 0;
            @(negedge clk);
            set_in(1, 1'b1, 1'b0, 16'd200, 16'd3);
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (done8) begin
                    ndone++;
                    if (ndone == 1) begin
                        c1 = c;
                        check("b2b_first_out", {16'd0, out8}, 32'd600);
                        set_in(1, 1'b1, 1'b0, 16'd255, 16'd255);
                    end else begin
                        check("b2b_second_out", {16'd0, out8}, 32'h0000_FE01);
                        check("b2b_spacing", 32'(c - c1), 32'd9);
                        break;
                    end
                end else if (ndone == 1 && c == c1 + 1) begin
                    set_in(1, 1'b0, 1'b0, 16'd0, 16'd0);
                end
            end
            check("b2b_done_count", 32'(ndone), 32'd2);
            set_in(1, 1'b0, 1'b0, 16'd0, 16'd0);
        end

        // start pulsed during RUN must be ignored
        begin
            int ndone;
            logic [15:0] first;
            ndone = 0;
            first = '0;
            @(negedge clk);
            set_in(1, 1'b1, 1'b0, 16'd5, 16'd6);
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (done8) begin
                    ndone++;
                    if (ndone == 1) first = out8;
                end
                if (c == 1) set_in(1, 1'b0, 1'b0, 16'd5, 16'd6);
                if (c == 3) set_in(1, 1'b1, 1'b0, 16'd9, 16'd9);
                if (c == 4) set_in(1, 1'b0, 1'b0, 16'd9, 16'd9);
            end
            check("rej_done_count", 32'(ndone), 32'd1);
            check("rej_out", {16'd0, first}, 32'd30);
            check("rej_out_hold", {16'd0, out8}, 32'd30);
        end

        // reset during RUN aborts the operation
        begin
            int ndone;
            ndone = 0;
            @(negedge clk);
            set_in(1, 1'b1, 1'b0, 16'd100, 16'd100);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (c == 1) set_in(1, 1'b0, 1'b0, 16'd0, 16'd0);
            end
            rst = 1'b1;
            @(negedge clk);
            check("rstmid_out", {16'd0, out8}, 32'd0);
            check("rstmid_busy", 32'(busy8), 32'd0);
            check("rstmid_done", 32'(done8), 32'd0);
            rst = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done8) ndone++;
            end
            check("rstmid_no_done", 32'(ndone), 32'd0);
            do_op(1, 1'b0, 16'd2, 16'd3, 32'd6, "rstmid_after");
        end

        // randomized 16-bit stream with scoreboard
        begin
            int gap;
            logic got;
            logic md;
            logic [15:0] xv;
            logic [15:0] yv;
            @(negedge clk);
            for (int op = 0; op < 2000; op++) begin
                md = 1'($urandom_range(0, 1));
                xv = 16'($urandom);
                yv = 16'($urandom);
                if (op % 16 == 0) xv = 16'h8000;
                set_in(2, 1'b1, md, xv, yv);
                exp_q.push_back(model(16, md, xv, yv));
                got = 1'b0;
                for (int c = 1; c <= 40; c++) begin
                    @(negedge clk);
                    if (done16) begin
                        got = 1'b1;
                        if (exp_q.size() == 0) check("rand_unexpected_done", 32'd1, 32'd0);
                        else check($sformatf("rand_op%0d", op), out16, exp_q.pop_front());
                        break;
                    end
                    if (c == 1) set_in(2, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
                end
                if (!got) begin
                    check("rand_timeout", 32'd0, 32'd1);
                    break;
                end
                gap = $urandom_range(0, 3);
                if (gap != 0) begin
                    set_in(2, 1'b0, 1'b0, 16'd0, 16'd0);
                    repeat (gap) @(negedge clk);
                end
            end
            set_in(2, 1'b0, 1'b0, 16'd0, 16'd0);
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
